// File: rtl/ibex_pkg.sv
// Shared types for the multiply/divide issue driver: operator encoding,
// driver FSM states and watchdog counter width.
package ibex_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'b00,
    MD_OP_MULH = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_REM  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MDD_IDLE,
    MDD_BUSY,
    MDD_RESP
  } md_drv_state_e;

  localparam int unsigned MD_DRV_CNT_W = 8;

endpackage

// File: rtl/ibex_multdiv_driver_if.sv
// Request/response channels between an issuer (ID stage or BIST sequencer)
// and the multdiv driver.
interface ibex_multdiv_driver_if;
  import ibex_pkg::*;

  logic        req_valid;
  logic        req_ready;
  md_op_e      req_op;
  logic [1:0]  req_signed_mode;
  logic [31:0] req_op_a;
  logic [31:0] req_op_b;
  logic        req_data_ind_timing;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_error;

  modport master (
    output req_valid, req_op, req_signed_mode, req_op_a, req_op_b,
           req_data_ind_timing, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_error
  );

  modport slave (
    input  req_valid, req_op, req_signed_mode, req_op_a, req_op_b,
           req_data_ind_timing, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_error
  );

endinterface

// File: rtl/ibex_multdiv_drv_watchdog.sv
// BUSY-cycle watchdog for the multdiv driver; only built when
// MULTDIV_DRV_TIMEOUT_EN is defined.
`ifdef MULTDIV_DRV_TIMEOUT_EN
module ibex_multdiv_drv_watchdog
  import ibex_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 48
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam logic [MD_DRV_CNT_W-1:0] LastCnt = MD_DRV_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [MD_DRV_CNT_W-1:0] cnt_q;

  // Fires in the last permitted BUSY cycle, so the abort edge is the
  // TIMEOUT_CYCLES-th cycle without a result.
  assign expired_o = count_i && (cnt_q == LastCnt);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (count_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/ibex_multdiv_driver.sv
// Issue-side driver for the fast multdiv unit: latches one request, owns the
// intermediate registers and the shared adder, returns the unit's result.
// Optional BUSY watchdog and sticky fault: define MULTDIV_DRV_TIMEOUT_EN.
module ibex_multdiv_driver
  import ibex_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 48
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  ibex_multdiv_driver_if.slave bus,
  output logic                 fault_o,
  output logic                 md_mult_en_o,
  output logic                 md_div_en_o,
  output logic                 md_mult_sel_o,
  output logic                 md_div_sel_o,
  output md_op_e               md_operator_o,
  output logic [1:0]           md_signed_mode_o,
  output logic [31:0]          md_op_a_o,
  output logic [31:0]          md_op_b_o,
  output logic                 md_data_ind_timing_o,
  input  logic [32:0]          md_alu_operand_a_i,
  input  logic [32:0]          md_alu_operand_b_i,
  output logic [33:0]          md_alu_adder_ext_o,
  output logic [31:0]          md_alu_adder_o,
  output logic                 md_equal_to_zero_o,
  input  logic [31:0]          md_result_i,
  input  logic                 md_valid_i,
  input  logic [33:0]          md_imd_val_d_i [2],
  input  logic [1:0]           md_imd_val_we_i,
  output logic [33:0]          md_imd_val_q_o [2]
);

  if (TIMEOUT_CYCLES < 40 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 40..255");
  end

  md_drv_state_e state_q;
  logic          req_ready_q, rsp_valid_q, rsp_error_q, fault_q;
  logic [31:0]   rsp_result_q;
  logic          mult_en_q, div_en_q;
  logic          accept;
  logic          timeout_hit;

  assign accept = bus.req_valid && req_ready_q;

`ifdef MULTDIV_DRV_TIMEOUT_EN
  logic busy_wait;
  assign busy_wait = (state_q == MDD_BUSY) && !md_valid_i;

  ibex_multdiv_drv_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (accept),
    .count_i   (busy_wait),
    .expired_o (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  assign md_alu_adder_ext_o = {1'b0, md_alu_operand_a_i} + {1'b0, md_alu_operand_b_i};
  assign md_alu_adder_o     = md_alu_adder_ext_o[32:1];
  assign md_equal_to_zero_o = (md_op_b_o == '0);

  // NOTE: only two entries, so they are reset like ordinary flops; a real
  // memory array would normally be left without reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) md_imd_val_q_o[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (md_imd_val_we_i[i]) md_imd_val_q_o[i] <= md_imd_val_d_i[i];
      end
    end
  end

  // NOTE: non-blocking assignments throughout, so every register samples
  // the pre-edge value of the others regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q              <= MDD_IDLE;
      req_ready_q          <= 1'b0;
      rsp_valid_q          <= 1'b0;
      rsp_error_q          <= 1'b0;
      rsp_result_q         <= '0;
      fault_q              <= 1'b0;
      mult_en_q            <= 1'b0;
      div_en_q             <= 1'b0;
      md_operator_o        <= MD_OP_MULL;
      md_signed_mode_o     <= '0;
      md_op_a_o            <= '0;
      md_op_b_o            <= '0;
      md_data_ind_timing_o <= 1'b0;
    end else begin
      case (state_q)
        MDD_IDLE: begin
          // A faulted unit is in an unknown state, so stop accepting work.
          req_ready_q <= !fault_q;
          if (accept) begin
            req_ready_q          <= 1'b0;
            md_operator_o        <= bus.req_op;
            md_signed_mode_o     <= bus.req_signed_mode;
            md_op_a_o            <= bus.req_op_a;
            md_op_b_o            <= bus.req_op_b;
            md_data_ind_timing_o <= bus.req_data_ind_timing;
            mult_en_q            <= !bus.req_op[1];
            div_en_q             <= bus.req_op[1];
            state_q              <= MDD_BUSY;
          end
        end
        MDD_BUSY: begin
          // Enable stays high through the valid cycle so the unit can
          // return to its own idle state.
          if (md_valid_i || timeout_hit) begin
            mult_en_q    <= 1'b0;
            div_en_q     <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= md_valid_i ? md_result_i : '0;
            rsp_error_q  <= timeout_hit;
            fault_q      <= fault_q | timeout_hit;
            state_q      <= MDD_RESP;
          end
        end
        MDD_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= !fault_q;
            state_q     <= MDD_IDLE;
          end
        end
        default: state_q <= MDD_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_error  = rsp_error_q;
  assign fault_o        = fault_q;
  assign md_mult_en_o   = mult_en_q;
  assign md_mult_sel_o  = mult_en_q;
  assign md_div_en_o    = div_en_q;
  assign md_div_sel_o   = div_en_q;

endmodule

// File: tb/tb_ibex_multdiv_driver.sv
// Scoreboard bench for ibex_multdiv_driver with a behavioural multdiv unit stub.
module tb_ibex_multdiv_driver;
  import ibex_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  ibex_multdiv_driver_if bus ();

  logic        fault;
  logic        mult_en, div_en, mult_sel, div_sel;
  md_op_e      md_operator;
  logic [1:0]  md_signed_mode;
  logic [31:0] md_op_a, md_op_b;
  logic        md_dit;
  logic [32:0] alu_a, alu_b;
  logic [33:0] adder_ext;
  logic [31:0] adder;
  logic        eq_zero;
  logic [31:0] md_result;
  logic        md_valid;
  logic [33:0] imd_d [2];
  logic [1:0]  imd_we;
  logic [33:0] imd_q [2];

  ibex_multdiv_driver #(.TIMEOUT_CYCLES(48)) dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .bus                  (bus),
    .fault_o              (fault),
    .md_mult_en_o         (mult_en),
    .md_div_en_o          (div_en),
    .md_mult_sel_o        (mult_sel),
    .md_div_sel_o         (div_sel),
    .md_operator_o        (md_operator),
    .md_signed_mode_o     (md_signed_mode),
    .md_op_a_o            (md_op_a),
    .md_op_b_o            (md_op_b),
    .md_data_ind_timing_o (md_dit),
    .md_alu_operand_a_i   (alu_a),
    .md_alu_operand_b_i   (alu_b),
    .md_alu_adder_ext_o   (adder_ext),
    .md_alu_adder_o       (adder),
    .md_equal_to_zero_o   (eq_zero),
    .md_result_i          (md_result),
    .md_valid_i           (md_valid),
    .md_imd_val_d_i       (imd_d),
    .md_imd_val_we_i      (imd_we),
    .md_imd_val_q_o       (imd_q)
  );

  typedef struct {
    logic [31:0] result;
    logic        error;
    int          mult_cyc;
    int          div_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural multdiv unit: computes from the driver's latched outputs.
  function automatic logic [31:0] unit_model(logic [1:0] op, logic [1:0] mode,
                                             logic [31:0] a, logic [31:0] b);
    logic signed [32:0] sa, sb;
    logic signed [65:0] p;
    sa = $signed({mode[0] & a[31], a});
    sb = $signed({mode[1] & b[31], b});
    p  = sa * sb;
    case (op)
      2'd0: return p[31:0];
      2'd1: return p[63:32];
      2'd2: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (mode == 2'b11) return $signed(a) / $signed(b);
        return a / b;
      end
      default: begin
        if (b == 0) return a;
        if (mode == 2'b11) return $signed(a) % $signed(b);
        return a % b;
      end
    endcase
  endfunction

  int   stub_cnt;
  logic stub_stall = 1'b0;

  always @(negedge clk_i or negedge rst_ni) begin
    int lat;
    if (!rst_ni) begin
      md_valid  = 1'b0;
      md_result = '0;
      stub_cnt  = 0;
    end else if (mult_en || div_en) begin
      if (div_en) lat = (eq_zero && !md_dit) ? 2 : 35;
      else        lat = 3;
      md_valid  = !stub_stall && (stub_cnt == lat - 1);
      md_result = unit_model(md_operator, md_signed_mode, md_op_a, md_op_b);
      stub_cnt++;
    end else begin
      md_valid = 1'b0;
      stub_cnt = 0;
    end
  end

  // Monitor: counts enable cycles and compares each response handshake.
  int mult_seen = 0;
  int div_seen  = 0;

  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_ni) begin
      mult_seen = 0;
      div_seen  = 0;
    end else begin
      if (mult_en && mult_sel) mult_seen++;
      if (div_en && div_sel)   div_seen++;
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got result 0x%0h with no request outstanding",
                   bus.rsp_result);
        end else begin
          e = sb_q.pop_front();
          check("rsp_result", bus.rsp_result, e.result);
          check("rsp_error", bus.rsp_error, e.error);
          check("mult_en_cycles", mult_seen, e.mult_cyc);
          check("div_en_cycles", div_seen, e.div_cyc);
        end
        mult_seen = 0;
        div_seen  = 0;
      end
    end
  end

  task automatic issue(md_op_e op, logic [1:0] mode, logic [31:0] a, logic [31:0] b,
                       logic dit, logic [31:0] res, logic err, int mc, int dc, bit push);
    int n = 0;
    @(negedge clk_i);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_wait: got req_ready 0 expected 1 within 100 cycles");
      return;
    end
    bus.req_valid           = 1'b1;
    bus.req_op              = op;
    bus.req_signed_mode     = mode;
    bus.req_op_a            = a;
    bus.req_op_b            = b;
    bus.req_data_ind_timing = dit;
    if (push) sb_q.push_back('{res, err, mc, dc});
    @(negedge clk_i);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_wait: got %0d responses pending expected 0 within %0d cycles",
               sb_q.size(), budget);
      sb_q.delete();
    end
  endtask

  typedef struct {
    md_op_e      op;
    logic [1:0]  mode;
    logic [31:0] a, b;
    logic        dit;
    logic [31:0] res;
    int          mc, dc;
  } vec_t;

  vec_t vecs[8] = '{
    '{MD_OP_MULL, 2'b11, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFEB, 3, 0},
    '{MD_OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 3, 0},
    '{MD_OP_DIV,  2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'hFFFF_FFFD, 0, 35},
    '{MD_OP_REM,  2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 0, 35},
    '{MD_OP_DIV,  2'b11, 32'h0000_0005, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 0, 2},
    '{MD_OP_REM,  2'b11, 32'h0000_0005, 32'h0000_0000, 1'b0, 32'h0000_0005, 0, 2},
    '{MD_OP_DIV,  2'b11, 32'h0000_0005, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 0, 35},
    '{MD_OP_REM,  2'b11, 32'h0000_0005, 32'h0000_0000, 1'b1, 32'h0000_0005, 0, 35}
  };

  task automatic check_reset_state(string tag);
    check({tag, "_flags"},
          {bus.req_ready, bus.rsp_valid, bus.rsp_error, fault, mult_en, div_en,
           mult_sel, div_sel, md_operator, md_signed_mode, md_dit}, 13'h0);
    check({tag, "_op_a"}, md_op_a, 32'h0);
    check({tag, "_op_b"}, md_op_b, 32'h0);
    check({tag, "_result"}, bus.rsp_result, 32'h0);
    check({tag, "_imd0"}, imd_q[0], 34'h0);
    check({tag, "_imd1"}, imd_q[1], 34'h0);
  endtask

  typedef struct {
    logic [32:0] a, b;
    logic [33:0] ext;
    logic [31:0] sum;
  } add_t;

  add_t adds[4] = '{
    '{33'h0_0000_0003, 33'h0_0000_0005, 34'h0_0000_0008, 32'h0000_0004},
    '{33'h1_FFFF_FFFF, 33'h0_0000_0001, 34'h2_0000_0000, 32'h0000_0000},
    '{33'h1_2345_6789, 33'h0_1111_1111, 34'h1_3456_789A, 32'h9A2B_3C4D},
    '{33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 34'h3_FFFF_FFFE, 32'hFFFF_FFFF}
  };

  initial begin
    bus.req_valid           = 1'b0;
    bus.req_op              = MD_OP_MULL;
    bus.req_signed_mode     = 2'b00;
    bus.req_op_a            = '0;
    bus.req_op_b            = '0;
    bus.req_data_ind_timing = 1'b0;
    bus.rsp_ready           = 1'b1;
    alu_a  = '0;
    alu_b  = '0;
    imd_d[0] = '0;
    imd_d[1] = '0;
    imd_we = 2'b00;

    repeat (3) @(negedge clk_i);
    check_reset_state("reset");
    rst_ni = 1'b1;

    foreach (adds[i]) begin
      @(negedge clk_i);
      alu_a = adds[i].a;
      alu_b = adds[i].b;
      #1;
      check("adder_ext", adder_ext, adds[i].ext);
      check("adder", adder, adds[i].sum);
    end

    @(negedge clk_i);
    imd_d[0] = 34'h2_DEAD_BEEF;
    imd_d[1] = 34'h1_2345_6789;
    imd_we   = 2'b01;
    @(negedge clk_i);
    imd_we   = 2'b00;
    imd_d[0] = '0;
    check("imd0_load", imd_q[0], 34'h2_DEAD_BEEF);
    check("imd1_untouched", imd_q[1], 34'h0);
    @(negedge clk_i);
    check("imd0_hold", imd_q[0], 34'h2_DEAD_BEEF);
    imd_we = 2'b10;
    @(negedge clk_i);
    imd_we = 2'b00;
    check("imd1_load", imd_q[1], 34'h1_2345_6789);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].dit,
            vecs[i].res, 1'b0, vecs[i].mc, vecs[i].dc, 1'b1);
      wait_done(100);
    end
    check("eq_zero_latched", eq_zero, 1'b1);

    // Response backpressure.
    bus.rsp_ready = 1'b0;
    issue(MD_OP_MULL, 2'b00, 32'd3, 32'd4, 1'b0, 32'd12, 1'b0, 3, 0, 1'b1);
    for (int n = 0; n < 50 && !bus.rsp_valid; n++) @(negedge clk_i);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk_i);
      check("bp_hold", {bus.rsp_valid, bus.req_ready, mult_en, div_en, bus.rsp_error}, 5'b10000);
      check("bp_result", bus.rsp_result, 32'd12);
    end
    bus.rsp_ready = 1'b1;
    wait_done(20);

`ifdef MULTDIV_DRV_TIMEOUT_EN
    stub_stall = 1'b1;
    issue(MD_OP_MULL, 2'b00, 32'd1, 32'd1, 1'b0, 32'h0, 1'b1, 48, 0, 1'b1);
    wait_done(200);
    stub_stall = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk_i);
      check("fault_sticky", {fault, bus.req_ready}, 2'b10);
    end
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("fault_cleared", fault, 1'b0);
    rst_ni = 1'b1;
`endif

    // Asynchronous reset in the middle of a divide.
    issue(MD_OP_DIV, 2'b00, 32'd100, 32'd7, 1'b0, 32'h0, 1'b0, 0, 0, 1'b0);
    repeat (5) @(negedge clk_i);
    check("mid_div_busy", div_en, 1'b1);
    #2 rst_ni = 1'b0;
    #1 check_reset_state("async_reset");
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    issue(MD_OP_MULL, 2'b00, 32'd3, 32'd4, 1'b0, 32'd12, 1'b0, 3, 0, 1'b1);
    wait_done(100);
    repeat (2) @(negedge clk_i);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test expected finish before 200000");
    $fatal(1, "bench time limit reached");
  end

endmodule
